// File: rtl/io_port_unit_if.sv
// Register-bus interface between the data unit (master) and io_port_unit (slave).
// Carries the read/write strobes, read response, error pulse and interrupt level.
interface io_port_unit_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ADDR;
    logic              WR_EN;
    logic [1:0]        WMODE;
    logic [DATA_W-1:0] WDATA;
    logic              RD_EN;
    logic [DATA_W-1:0] RDATA;
    logic              RVALID;
    logic              ERR;
    logic              IRQ;

    modport master (
        output ADDR, WR_EN, WMODE, WDATA, RD_EN,
        input  RDATA, RVALID, ERR, IRQ
    );

    modport slave (
        input  ADDR, WR_EN, WMODE, WDATA, RD_EN,
        output RDATA, RVALID, ERR, IRQ
    );
endinterface

// File: rtl/io_port_unit.sv
// Memory-mapped I/O port controller: output registers with load/set/clear/toggle
// writes, synchronised input ports, per-port change flags and a masked interrupt.
module io_port_unit #(
    parameter int DATA_W      = 8,
    parameter int N_OUT       = 8,
    parameter int N_IN        = 8,
    parameter int ADDR_W      = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    io_port_unit_if.slave           bus,
    output logic [N_OUT*DATA_W-1:0] PORT_OUT,
    input  logic [N_IN*DATA_W-1:0]  PORT_IN
);
    localparam int FLAGS_ADDR = N_OUT + N_IN;
    localparam int MASK_ADDR  = N_OUT + N_IN + 1;
    localparam int N_MAPPED   = N_OUT + N_IN + 2;
    localparam int WARM_MAX   = SYNC_STAGES + 1;
    localparam int CNT_W      = $clog2(WARM_MAX + 1);

    function automatic logic [DATA_W-1:0] apply_mode(
        input logic [1:0]        mode,
        input logic [DATA_W-1:0] cur,
        input logic [DATA_W-1:0] wd
    );
        case (mode)
            2'b00:   return wd;
            2'b01:   return cur | wd;
            2'b10:   return cur & ~wd;
            default: return cur ^ wd;
        endcase
    endfunction

    int   addr_int;
    logic is_flags;
    logic is_mask;
    logic is_unmapped;

    assign addr_int    = int'(bus.ADDR);
    assign is_flags    = (addr_int == FLAGS_ADDR);
    assign is_mask     = (addr_int == MASK_ADDR);
    assign is_unmapped = (addr_int >= N_MAPPED);

    logic [N_IN*DATA_W-1:0] sync_reg [SYNC_STAGES];
    logic [N_IN*DATA_W-1:0] prev_reg;
    logic [N_IN*DATA_W-1:0] s_val;
    logic [N_IN-1:0]        flags_reg;
    logic [N_IN-1:0]        flags_next;
    logic [N_IN-1:0]        mask_reg;
    logic [N_IN-1:0]        mask_next;
    logic [N_IN-1:0]        change;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   warm_done;
    logic [DATA_W-1:0]      rd_mux;
    logic [DATA_W-1:0]      mask_mod;
    logic [DATA_W-1:0]      rdata_reg;
    logic                   rvalid_reg;
    logic                   err_reg;
    logic                   irq_reg;

    assign s_val     = sync_reg[SYNC_STAGES-1];
    assign warm_done = (cnt_reg == CNT_W'(WARM_MAX));

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
        logic [DATA_W-1:0] port_reg;

        always_ff @(posedge CLK) begin
            if (RESET) begin
                port_reg <= '0;
            end else if (bus.WR_EN && addr_int == gi) begin
                port_reg <= apply_mode(bus.WMODE, port_reg, bus.WDATA);
            end
        end

        assign PORT_OUT[gi*DATA_W +: DATA_W] = port_reg;
    end

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_chg
        assign change[gi] = |(s_val[gi*DATA_W +: DATA_W] ^ prev_reg[gi*DATA_W +: DATA_W]);
    end

    // A new change is OR-ed in after the W1C so a same-cycle detection survives the clear.
    always_comb begin
        flags_next = flags_reg;
        if (bus.WR_EN && is_flags) begin
            flags_next = flags_next & ~bus.WDATA[N_IN-1:0];
        end
        if (warm_done) begin
            flags_next = flags_next | change;
        end
    end

    always_comb begin
        mask_mod  = apply_mode(bus.WMODE, DATA_W'(mask_reg), bus.WDATA);
        mask_next = mask_mod[N_IN-1:0];
    end

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (addr_int == k) rd_mux = PORT_OUT[k*DATA_W +: DATA_W];
        end
        for (int k = 0; k < N_IN; k++) begin
            if (addr_int == N_OUT + k) rd_mux = s_val[k*DATA_W +: DATA_W];
        end
        if (is_flags) rd_mux = DATA_W'(flags_reg);
        if (is_mask)  rd_mux = DATA_W'(mask_reg);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_reg[s] <= '0;
            prev_reg   <= '0;
            cnt_reg    <= '0;
            flags_reg  <= '0;
            mask_reg   <= '0;
            irq_reg    <= 1'b0;
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            sync_reg[0] <= PORT_IN;
            for (int s = 1; s < SYNC_STAGES; s++) sync_reg[s] <= sync_reg[s-1];
            prev_reg <= s_val;
            if (!warm_done) cnt_reg <= cnt_reg + CNT_W'(1);
            flags_reg <= flags_next;
            if (bus.WR_EN && is_mask) mask_reg <= mask_next;
            irq_reg    <= |(flags_reg & mask_reg);
            rvalid_reg <= bus.RD_EN;
            err_reg    <= (bus.RD_EN || bus.WR_EN) && is_unmapped;
            if (bus.RD_EN) rdata_reg <= rd_mux;
        end
    end

    assign bus.RDATA  = rdata_reg;
    assign bus.RVALID = rvalid_reg;
    assign bus.ERR    = err_reg;
    assign bus.IRQ    = irq_reg;
endmodule

// File: tb/tb_io_port_unit.sv
// Directed bench for io_port_unit: write modes, read collision, input sync,
// change flags with W1C priority, unmapped access and mid-operation reset.
module tb_io_port_unit;
    localparam int DATA_W      = 8;
    localparam int N_OUT       = 8;
    localparam int N_IN        = 8;
    localparam int ADDR_W      = 5;
    localparam int SYNC_STAGES = 2;
    localparam logic [ADDR_W-1:0] A_FLAGS = 5'd16;
    localparam logic [ADDR_W-1:0] A_MASK  = 5'd17;
    localparam logic [ADDR_W-1:0] A_UNMAP = 5'd18;

    logic                    CLK = 1'b0;
    logic                    RESET;
    logic [N_OUT*DATA_W-1:0] PORT_OUT;
    logic [N_IN*DATA_W-1:0]  PORT_IN;

    io_port_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    io_port_unit #(
        .DATA_W(DATA_W), .N_OUT(N_OUT), .N_IN(N_IN),
        .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus),
        .PORT_OUT(PORT_OUT), .PORT_IN(PORT_IN)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_idle();
        bus.WR_EN = 1'b0;
        bus.RD_EN = 1'b0;
        bus.WMODE = 2'b00;
        bus.WDATA = '0;
        bus.ADDR  = '0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [1:0] m, input logic [DATA_W-1:0] d);
        bus.ADDR = a; bus.WMODE = m; bus.WDATA = d; bus.WR_EN = 1'b1;
        tick();
        $display("wr addr=%0d mode=%0d data=%02h err=%0b", a, m, d, bus.ERR);
        bus_idle();
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        bus.ADDR = a; bus.RD_EN = 1'b1;
        tick();
        $display("rd addr=%0d rdata=%02h rvalid=%0b err=%0b", a, bus.RDATA, bus.RVALID, bus.ERR);
        bus_idle();
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        PORT_IN = '0;
        PORT_IN[2*DATA_W +: DATA_W] = 8'h3C;
        bus_idle();
        tick(); tick();
        RESET = 1'b0;
        checks++; if (PORT_OUT !== '0) begin failures++; $display("FAIL reset_port_out: got %h expected 0", PORT_OUT); end
        checks++; if (bus.RVALID !== 1'b0 || bus.ERR !== 1'b0 || bus.IRQ !== 1'b0) begin
            failures++; $display("FAIL reset_pulses: rvalid=%b err=%b irq=%b expected 0 0 0", bus.RVALID, bus.ERR, bus.IRQ); end
        checks++; if (bus.RDATA !== 8'h00) begin failures++; $display("FAIL reset_rdata: got %h expected 00", bus.RDATA); end
        repeat (5) tick();
        do_read(A_FLAGS);
        checks++; if (bus.RDATA !== 8'h00 || bus.RVALID !== 1'b1) begin
            failures++; $display("FAIL warmup_flags: got %h rvalid=%b expected 00 rvalid=1", bus.RDATA, bus.RVALID); end
        do_read(5'd10);
        checks++; if (bus.RDATA !== 8'h3C) begin failures++; $display("FAIL sync_read_port2: got %h expected 3c", bus.RDATA); end
        do_read(A_MASK);
        checks++; if (bus.RDATA !== 8'h00) begin failures++; $display("FAIL reset_mask: got %h expected 00", bus.RDATA); end
    endtask

    task automatic test_write_modes();
        do_write(5'd3, 2'b00, 8'hA5);
        checks++; if (PORT_OUT !== 64'h00000000_A5000000) begin failures++; $display("FAIL mode_load: got %h expected 00000000a5000000", PORT_OUT); end
        do_write(5'd3, 2'b01, 8'h0F);
        checks++; if (PORT_OUT[3*DATA_W +: DATA_W] !== 8'hAF) begin failures++; $display("FAIL mode_set: got %h expected af", PORT_OUT[3*DATA_W +: DATA_W]); end
        do_write(5'd3, 2'b10, 8'hA0);
        checks++; if (PORT_OUT[3*DATA_W +: DATA_W] !== 8'h0F) begin failures++; $display("FAIL mode_clear: got %h expected 0f", PORT_OUT[3*DATA_W +: DATA_W]); end
        do_write(5'd3, 2'b11, 8'hFF);
        checks++; if (PORT_OUT !== 64'h00000000_F0000000) begin failures++; $display("FAIL mode_toggle: got %h expected 00000000f0000000", PORT_OUT); end
    endtask

    task automatic test_read_collision();
        bus.ADDR = 5'd3; bus.RD_EN = 1'b1; bus.WR_EN = 1'b1; bus.WMODE = 2'b00; bus.WDATA = 8'h11;
        tick();
        $display("rd+wr addr=3 data=11 rdata=%02h rvalid=%0b", bus.RDATA, bus.RVALID);
        bus_idle();
        checks++; if (bus.RVALID !== 1'b1 || bus.RDATA !== 8'hF0) begin
            failures++; $display("FAIL collision_read: got %h rvalid=%b expected f0 rvalid=1", bus.RDATA, bus.RVALID); end
        tick();
        checks++; if (bus.RVALID !== 1'b0 || bus.RDATA !== 8'hF0) begin
            failures++; $display("FAIL rvalid_pulse_hold: got %h rvalid=%b expected f0 rvalid=0", bus.RDATA, bus.RVALID); end
        do_read(5'd3);
        checks++; if (bus.RDATA !== 8'h11) begin failures++; $display("FAIL read_after_write: got %h expected 11", bus.RDATA); end
    endtask

    task automatic test_change_flag();
        do_write(A_MASK, 2'b00, 8'h04);
        do_read(A_MASK);
        checks++; if (bus.RDATA !== 8'h04) begin failures++; $display("FAIL mask_readback: got %h expected 04", bus.RDATA); end
        PORT_IN[2*DATA_W +: DATA_W] = 8'h3D;
        tick(); tick();
        bus.ADDR = A_FLAGS; bus.RD_EN = 1'b1;
        tick();
        checks++; if (bus.RDATA !== 8'h00 || bus.IRQ !== 1'b0) begin
            failures++; $display("FAIL flag_not_early: got %h irq=%b expected 00 irq=0", bus.RDATA, bus.IRQ); end
        tick();
        bus_idle();
        checks++; if (bus.RDATA !== 8'h04) begin failures++; $display("FAIL flag_set_timing: got %h expected 04", bus.RDATA); end
        checks++; if (bus.IRQ !== 1'b1) begin failures++; $display("FAIL irq_raise: got %b expected 1", bus.IRQ); end
    endtask

    task automatic test_w1c_priority();
        PORT_IN[2*DATA_W +: DATA_W] = 8'h3F;
        tick(); tick();
        do_write(A_FLAGS, 2'b11, 8'h04);
        do_read(A_FLAGS);
        checks++; if (bus.RDATA !== 8'h04) begin failures++; $display("FAIL set_beats_w1c: got %h expected 04", bus.RDATA); end
        do_write(A_FLAGS, 2'b00, 8'h04);
        do_read(A_FLAGS);
        checks++; if (bus.RDATA !== 8'h00) begin failures++; $display("FAIL w1c_clear: got %h expected 00", bus.RDATA); end
        checks++; if (bus.IRQ !== 1'b0) begin failures++; $display("FAIL irq_drop: got %b expected 0", bus.IRQ); end
    endtask

    task automatic test_unmapped();
        do_read(A_UNMAP);
        checks++; if (bus.RVALID !== 1'b1 || bus.RDATA !== 8'h00 || bus.ERR !== 1'b1) begin
            failures++; $display("FAIL unmapped_read: rdata=%h rvalid=%b err=%b expected 00 1 1", bus.RDATA, bus.RVALID, bus.ERR); end
        tick();
        checks++; if (bus.ERR !== 1'b0) begin failures++; $display("FAIL err_pulse: got %b expected 0", bus.ERR); end
        do_write(A_UNMAP, 2'b00, 8'hFF);
        checks++; if (bus.ERR !== 1'b1) begin failures++; $display("FAIL unmapped_write_err: got %b expected 1", bus.ERR); end
        checks++; if (PORT_OUT !== 64'h00000000_11000000) begin failures++; $display("FAIL unmapped_no_effect: got %h expected 0000000011000000", PORT_OUT); end
        do_read(A_MASK);
        checks++; if (bus.RDATA !== 8'h04) begin failures++; $display("FAIL unmapped_mask_kept: got %h expected 04", bus.RDATA); end
        do_write(5'd10, 2'b00, 8'hFF);
        checks++; if (bus.ERR !== 1'b0) begin failures++; $display("FAIL input_write_no_err: got %b expected 0", bus.ERR); end
        do_read(5'd10);
        checks++; if (bus.RDATA !== 8'h3F) begin failures++; $display("FAIL input_write_ignored: got %h expected 3f", bus.RDATA); end
    endtask

    task automatic test_reset_mid();
        PORT_IN[2*DATA_W +: DATA_W] = 8'h00;
        tick(); tick(); tick();
        bus.ADDR = 5'd3; bus.RD_EN = 1'b1; RESET = 1'b1;
        tick();
        $display("rd addr=3 with reset rvalid=%0b", bus.RVALID);
        bus_idle();
        checks++; if (bus.RVALID !== 1'b0) begin failures++; $display("FAIL reset_drops_rvalid: got %b expected 0", bus.RVALID); end
        checks++; if (PORT_OUT !== '0 || bus.IRQ !== 1'b0) begin
            failures++; $display("FAIL reset_mid_state: port_out=%h irq=%b expected 0 0", PORT_OUT, bus.IRQ); end
        RESET = 1'b0;
        repeat (5) tick();
        do_read(A_FLAGS);
        checks++; if (bus.RDATA !== 8'h00) begin failures++; $display("FAIL reset_mid_flags: got %h expected 00", bus.RDATA); end
        do_read(A_MASK);
        checks++; if (bus.RDATA !== 8'h00) begin failures++; $display("FAIL reset_mid_mask: got %h expected 00", bus.RDATA); end
        checks++; if (bus.IRQ !== 1'b0) begin failures++; $display("FAIL reset_mid_irq: got %b expected 0", bus.IRQ); end
    endtask

    initial begin
        test_reset();
        test_write_modes();
        test_read_collision();
        test_change_flag();
        test_w1c_priority();
        test_unmapped();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
